// File: rtl/param_seq_detector_if.sv
//------------------------------------------------------------------------------
// param_seq_detector_if : serial stream, configuration and result signals
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface param_seq_detector_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               dout;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  dout, match_cnt, armed
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output dout, match_cnt, armed
  );
endinterface

`default_nettype wire

// File: rtl/param_seq_detector.sv
//------------------------------------------------------------------------------
// param_seq_detector : run-time programmable serial pattern detector
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 RST_LEN     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_seq_detector_if.slave   bus
);
  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_RST_LEN = LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic               hit;

  always_comb begin
    shifted  = {hist_q[MAX_LEN-2:0], bus.din};
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // fill+1 is computed one bit wider so it can reach MAX_LEN+1 without wrapping
    fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
    hit      = bus.din_valid && !bus.cfg_load &&
               (fill_inc >= {1'b0, len_q}) &&
               (((shifted ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = 1'b0;
    cnt_d     = cnt_q;

    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      overlap_d = bus.cfg_overlap;
      if (bus.cfg_len == '0) begin
        len_d = LEN_W'(1);
      end else if (bus.cfg_len > C_MAX_LEN) begin
        len_d = C_MAX_LEN;
      end else begin
        len_d = bus.cfg_len;
      end
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.din_valid) begin
      hist_d = shifted;
      fill_d = (fill_q == C_MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
      dout_d = hit;
      if (hit) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // non-overlap: the next match must be built from entirely fresh bits
        if (!overlap_q) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= RST_PATTERN;
      len_q     <= C_RST_LEN;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = (fill_q >= len_q);

endmodule

`default_nettype wire

// File: tb/tb_param_seq_detector.sv
//------------------------------------------------------------------------------
// tb_param_seq_detector : directed vectors, queued expectations, negedge monitor
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_seq_detector;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   sid;
  int   total;
  int   bad;

  typedef struct {
    int due;
    int id;
    bit ed;
    int ec;
    bit ca;
    bit ea;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  param_seq_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  param_seq_detector #(
    .MAX_LEN    (MAX_LEN),
    .CNT_W      (CNT_W),
    .RST_PATTERN(8'b0000_1011),
    .RST_LEN    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One stimulus cycle; its effect is visible after the following rising edge.
  task automatic step(input bit r, input bit v, input bit d, input bit ld, input bit clr,
                      input bit ed, input int ec, input bit ca, input bit ea);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.din_valid = v;
    bus.din       = d;
    bus.cfg_load  = ld;
    bus.cnt_clr   = clr;
    x.due = cyc + 1;
    x.id  = sid;
    x.ed  = ed;
    x.ec  = ec;
    x.ca  = ca;
    x.ea  = ea;
    exp_q.push_back(x);
    sid++;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ov,
                      input bit v, input bit d);
    @(negedge clk);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    step(1, v, d, 1, 0, 0, 0, 1, 0);
  endtask

  task automatic bit_in(input bit d, input bit ed, input int ec);
    step(1, 1, d, 0, 0, ed, ec, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      total++;
      if (bus.dout !== e.ed) begin
        bad++;
        $display("FAIL dout step%0d got=%0b exp=%0b", e.id, bus.dout, e.ed);
      end
      total++;
      if (int'(bus.match_cnt) != e.ec) begin
        bad++;
        $display("FAIL match_cnt step%0d got=%0d exp=%0d", e.id, bus.match_cnt, e.ec);
      end
      if (e.ca) begin
        total++;
        if (bus.armed !== e.ea) begin
          bad++;
          $display("FAIL armed step%0d got=%0b exp=%0b", e.id, bus.armed, e.ea);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    sid   = 0;
    rst_n = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);

    // default pattern 1011, overlap: 1,0,1,1,0,1,1
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 1, 1);
    bit_in(0, 0, 1);
    bit_in(1, 0, 1);
    bit_in(1, 1, 2);
    step(1, 0, 0, 0, 0, 0, 2, 0, 0);

    // 101, len 3, non-overlap: 1,0,1,0,1
    load(8'b0000_0101, 4'd3, 0, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 1, 0);
    bit_in(0, 0, 1);
    bit_in(1, 0, 1);

    // same with overlap
    load(8'b0000_0101, 4'd3, 1, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 1, 1);
    bit_in(0, 0, 1);
    bit_in(1, 1, 2);

    // 1011 with a 3-cycle invalid gap carrying din=1
    load(8'b0000_1011, 4'd4, 1, 0, 0);
    bit_in(1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    bit_in(1, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 1, 1);

    // len 1, non-overlap, six ones: counter saturates at 3
    load(8'b0000_0001, 4'd1, 0, 0, 0);
    bit_in(1, 1, 1);
    bit_in(1, 1, 2);
    bit_in(1, 1, 3);
    bit_in(1, 1, 3);
    bit_in(1, 1, 3);
    bit_in(1, 1, 3);
    step(1, 0, 0, 0, 0, 0, 3, 0, 0);

    // cfg_len 0 acts as len 1 (pattern bit 0 = 0)
    load(8'b0000_0000, 4'd0, 1, 0, 0);
    bit_in(0, 1, 1);
    bit_in(1, 0, 1);
    bit_in(0, 1, 2);

    // cfg_len 12 acts as len 8, pattern A5 sent first-bit-first
    load(8'hA5, 4'd12, 0, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 1, 1);

    // load concurrent with a valid matching bit: bit dropped
    load(8'b0000_0001, 4'd1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);

    // reset mid-pattern, then one bit: no stale match
    load(8'b0000_1011, 4'd4, 1, 0, 0);
    bit_in(1, 0, 0);
    bit_in(0, 0, 0);
    bit_in(1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_in(1, 0, 0);

    // finish 1011 with cnt_clr on the completing bit
    bit_in(0, 0, 0);
    bit_in(1, 0, 0);
    step(1, 1, 1, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
